// File: rtl/fifo_read_engine.sv
// Drains a programmed burst from a 1-cycle-latency FIFO read port onto a valid/ready stream.
// Two-entry holding buffer gives 1 word/cycle; first out_valid 3 cycles after start; reads throttle on backpressure.
module fifo_read_engine #(
  parameter int DWIDTH = 8,
  parameter int CNT_W  = 16
) (
  input  logic              rd_clk,
  input  logic              res,
  input  logic              empty,
  input  logic [DWIDTH-1:0] rdata,
  input  logic              underflow,
  output logic              rd_en,
  input  logic              start,
  input  logic [CNT_W-1:0]  burst_len,
  output logic              busy,
  output logic              done,
  output logic              out_valid,
  output logic [DWIDTH-1:0] out_data,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  rd_count,
  output logic              err_underflow
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [CNT_W-1:0]  issued_q, issued_d;
  logic [CNT_W-1:0]  rd_count_q, rd_count_d;
  logic [1:0]        occ_q, occ_d;
  logic              inflight_q, inflight_d;
  logic [DWIDTH-1:0] buf0_q, buf0_d;
  logic [DWIDTH-1:0] buf1_q, buf1_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              pop;
  logic              rd_en_c;
  logic [2:0]        occ_sum;

  always_comb begin
    pop     = (occ_q != 2'd0) && out_ready;
    // Words already owed to the buffer must leave room for this read.
    occ_sum = {1'b0, occ_q} + {2'b00, inflight_q};
    rd_en_c = (state_q == RUN) && !empty && (issued_q < len_q) &&
              (occ_sum < (3'd2 + {2'b00, pop}));
  end

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    issued_d   = issued_q;
    rd_count_d = rd_count_q;
    occ_d      = occ_q;
    inflight_d = rd_en_c;
    buf0_d     = buf0_q;
    buf1_d     = buf1_q;
    done_d     = 1'b0;
    err_d      = err_q;

    // buf0 is the head; it keeps its last value once the buffer empties.
    unique case ({inflight_q, pop})
      2'b01: begin
        occ_d = occ_q - 2'd1;
        if (occ_q == 2'd2) buf0_d = buf1_q;
      end
      2'b10: begin
        occ_d = occ_q + 2'd1;
        if (occ_q == 2'd0) buf0_d = rdata;
        else               buf1_d = rdata;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          buf0_d = rdata;
        end else begin
          buf0_d = buf1_q;
          buf1_d = rdata;
        end
      end
      default: ;
    endcase

    if (rd_en_c) issued_d = issued_q + CNT_ONE;
    if (pop && (rd_count_q != '1)) rd_count_d = rd_count_q + CNT_ONE;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          rd_count_d = '0;
          if (burst_len != '0) begin
            len_d    = burst_len;
            issued_d = '0;
            err_d    = 1'b0;
            state_d  = RUN;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (rd_en_c && (issued_d == len_q)) state_d = DRAIN;
      end
      DRAIN: begin
        if ((occ_d == 2'd0) && !inflight_d && (rd_count_d == len_q)) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (underflow) err_d = 1'b1;
  end

  always_ff @(posedge rd_clk or posedge res) begin
    if (res) begin
      state_q    <= IDLE;
      len_q      <= '0;
      issued_q   <= '0;
      rd_count_q <= '0;
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      buf0_q     <= '0;
      buf1_q     <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      rd_count_q <= rd_count_d;
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign rd_en         = rd_en_c;
  assign busy          = (state_q != IDLE);
  assign done          = done_q;
  assign out_valid     = (occ_q != 2'd0);
  assign out_data      = buf0_q;
  assign rd_count      = rd_count_q;
  assign err_underflow = err_q;

endmodule

// File: tb/tb_fifo_read_engine.sv
// Directed bench for fifo_read_engine with a behavioural 1-cycle-latency FIFO feeding it.
module tb_fifo_read_engine;

  logic        rd_clk;
  logic        res;
  logic        empty;
  logic [7:0]  rdata;
  logic        underflow;
  logic        rd_en;
  logic        start;
  logic [15:0] burst_len;
  logic        busy;
  logic        done;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;
  logic [15:0] rd_count;
  logic        err_underflow;

  fifo_read_engine #(.DWIDTH(8), .CNT_W(16)) dut (
    .rd_clk        (rd_clk),
    .res           (res),
    .empty         (empty),
    .rdata         (rdata),
    .underflow     (underflow),
    .rd_en         (rd_en),
    .start         (start),
    .burst_len     (burst_len),
    .busy          (busy),
    .done          (done),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .out_ready     (out_ready),
    .rd_count      (rd_count),
    .err_underflow (err_underflow)
  );

  initial begin
    rd_clk = 1'b0;
    forever #5 rd_clk = ~rd_clk;
  end

  // FIFO model: read data appears the cycle after rd_en is sampled.
  logic [7:0] mem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign empty = (rd_ptr == wr_ptr);

  always @(posedge rd_clk) begin
    if (rd_en) begin
      rdata  <= mem[rd_ptr];
      rd_ptr <= rd_ptr + 1;
    end
  end

  int errors = 0;
  int checks = 0;
  logic [7:0] got_q [$];
  logic [7:0] pend_q [$];
  int seen_done;
  int viol;
  int stall;

  typedef struct {
    logic        start;
    logic [15:0] len;
    logic        rdy;
    logic        e_rd_en;
    logic        e_vld;
    logic [7:0]  e_dat;
    logic        e_done;
    logic        e_busy;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    mem[wr_ptr] = d;
    wr_ptr = wr_ptr + 1;
  endtask

  // Called just after a negedge with inputs applied; runs until done or budget.
  task automatic collect(input int max_cyc, input int push_at);
    seen_done = 0;
    viol = 0;
    stall = 0;
    for (int c = 0; c < max_cyc; c++) begin
      if (c == push_at) while (pend_q.size() > 0) push(pend_q.pop_front());
      #1;
      if (rd_en && empty) viol++;
      if (busy && empty && !rd_en) stall++;
      if (out_valid && out_ready) got_q.push_back(out_data);
      if (done) begin
        seen_done = 1;
        break;
      end
      @(negedge rd_clk);
      start = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    res = 1'b1;
    underflow = 1'b0;
    start = 1'b0;
    burst_len = '0;
    out_ready = 1'b0;

    vecs[0] = '{1'b1, 16'd4, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'd0};
    vecs[1] = '{1'b0, 16'd0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 16'd0};
    vecs[2] = '{1'b0, 16'd0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 16'd0};
    vecs[3] = '{1'b0, 16'd0, 1'b1, 1'b1, 1'b1, 8'h11, 1'b0, 1'b1, 16'd0};
    vecs[4] = '{1'b0, 16'd0, 1'b1, 1'b1, 1'b1, 8'h22, 1'b0, 1'b1, 16'd1};
    vecs[5] = '{1'b0, 16'd0, 1'b1, 1'b0, 1'b1, 8'h33, 1'b0, 1'b1, 16'd2};
    vecs[6] = '{1'b0, 16'd0, 1'b1, 1'b0, 1'b1, 8'h44, 1'b0, 1'b1, 16'd3};
    vecs[7] = '{1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 8'h44, 1'b1, 1'b1, 16'd4};
    vecs[8] = '{1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 8'h44, 1'b0, 1'b0, 16'd4};

    // Reset state
    repeat (2) @(negedge rd_clk);
    #1;
    chk("reset rd_en", rd_en, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset out_valid", out_valid, 0);
    chk("reset out_data", out_data, 0);
    chk("reset rd_count", rd_count, 0);
    chk("reset err", err_underflow, 0);
    @(negedge rd_clk);
    res = 1'b0;

    // Streaming burst, cycle by cycle
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    for (int i = 0; i < 9; i++) begin
      @(negedge rd_clk);
      start = vecs[i].start;
      burst_len = vecs[i].len;
      out_ready = vecs[i].rdy;
      #1;
      chk($sformatf("stream[%0d].rd_en", i), rd_en, vecs[i].e_rd_en);
      chk($sformatf("stream[%0d].out_valid", i), out_valid, vecs[i].e_vld);
      chk($sformatf("stream[%0d].out_data", i), out_data, vecs[i].e_dat);
      chk($sformatf("stream[%0d].done", i), done, vecs[i].e_done);
      chk($sformatf("stream[%0d].busy", i), busy, vecs[i].e_busy);
      chk($sformatf("stream[%0d].rd_count", i), rd_count, vecs[i].e_cnt);
    end

    // Backpressure: only two reads while the buffer is full and stalled
    for (int i = 0; i < 5; i++) push(8'hA1 + 8'(i));
    got_q.delete();
    @(negedge rd_clk);
    start = 1'b1; burst_len = 16'd5; out_ready = 1'b0;
    begin
      int nrd;
      nrd = 0;
      #1;
      if (rd_en) nrd++;
      for (int c = 1; c <= 6; c++) begin
        @(negedge rd_clk);
        start = 1'b0;
        #1;
        if (rd_en) nrd++;
        if (c >= 3) begin
          chk($sformatf("bp hold valid c%0d", c), out_valid, 1);
          chk($sformatf("bp hold data c%0d", c), out_data, 8'hA1);
        end
      end
      chk("bp rd_en count", nrd, 2);
    end
    @(negedge rd_clk);
    out_ready = 1'b1;
    collect(40, -1);
    chk("bp done seen", seen_done, 1);
    chk("bp rd_count", rd_count, 5);
    chk("bp word count", got_q.size(), 5);
    for (int i = 0; i < got_q.size(); i++)
      chk($sformatf("bp word%0d", i), got_q[i], 8'hA1 + 8'(i));

    // Empty stalls
    @(negedge rd_clk);
    got_q.delete();
    push(8'h51);
    pend_q.push_back(8'h52);
    pend_q.push_back(8'h53);
    start = 1'b1; burst_len = 16'd3; out_ready = 1'b1;
    collect(40, 5);
    chk("stall rd_en while empty", viol, 0);
    chk("stall observed", (stall >= 3) ? 1 : 0, 1);
    chk("stall done seen", seen_done, 1);
    chk("stall rd_count", rd_count, 3);
    chk("stall word count", got_q.size(), 3);
    for (int i = 0; i < got_q.size(); i++)
      chk($sformatf("stall word%0d", i), got_q[i], 8'h51 + 8'(i));

    // Zero-length burst
    @(negedge rd_clk);
    push(8'h61); push(8'h62);
    @(negedge rd_clk);
    start = 1'b1; burst_len = 16'd0;
    #1;
    chk("zero rd_en c0", rd_en, 0);
    @(negedge rd_clk);
    start = 1'b0;
    #1;
    chk("zero done", done, 1);
    chk("zero busy", busy, 0);
    chk("zero rd_count", rd_count, 0);
    chk("zero rd_en c1", rd_en, 0);
    @(negedge rd_clk);
    #1;
    chk("zero done one cycle", done, 0);
    chk("zero rd_en c2", rd_en, 0);

    // Start during RUN is ignored
    got_q.delete();
    @(negedge rd_clk);
    start = 1'b1; burst_len = 16'd2;
    @(negedge rd_clk);
    start = 1'b1; burst_len = 16'd5;
    #1;
    chk("ign busy", busy, 1);
    @(negedge rd_clk);
    start = 1'b0;
    collect(40, -1);
    chk("ign done seen", seen_done, 1);
    chk("ign rd_count", rd_count, 2);
    chk("ign word count", got_q.size(), 2);
    chk("ign fifo drained", empty, 1);

    // Underflow flag
    @(negedge rd_clk);
    underflow = 1'b1;
    #1;
    chk("uf not yet", err_underflow, 0);
    @(negedge rd_clk);
    underflow = 1'b0;
    #1;
    chk("uf set", err_underflow, 1);
    repeat (3) @(negedge rd_clk);
    #1;
    chk("uf sticky", err_underflow, 1);
    push(8'h71);
    got_q.delete();
    @(negedge rd_clk);
    start = 1'b1; burst_len = 16'd1;
    #1;
    chk("uf before start edge", err_underflow, 1);
    @(negedge rd_clk);
    start = 1'b0;
    #1;
    chk("uf cleared by start", err_underflow, 0);
    collect(20, -1);
    chk("uf burst done", seen_done, 1);
    chk("uf burst word", (got_q.size() == 1) ? got_q[0] : 8'hFF, 8'h71);

    // Reset mid-burst with one word buffered
    @(negedge rd_clk);
    push(8'h81); push(8'h82); push(8'h83);
    @(negedge rd_clk);
    start = 1'b1; burst_len = 16'd3; out_ready = 1'b1;
    repeat (4) begin
      @(negedge rd_clk);
      start = 1'b0;
    end
    #1;
    chk("mid pre valid", out_valid, 1);
    chk("mid pre data", out_data, 8'h82);
    chk("mid pre rd_count", rd_count, 1);
    res = 1'b1;
    #1;
    chk("mid rst out_valid", out_valid, 0);
    chk("mid rst rd_count", rd_count, 0);
    chk("mid rst busy", busy, 0);
    chk("mid rst rd_en", rd_en, 0);
    repeat (2) @(negedge rd_clk);
    #1;
    chk("mid rst held done", done, 0);
    chk("mid rst held out_data", out_data, 0);
    @(negedge rd_clk);
    res = 1'b0;
    begin
      int bad;
      bad = 0;
      for (int c = 0; c < 6; c++) begin
        #1;
        if (done || busy || out_valid) bad++;
        @(negedge rd_clk);
      end
      chk("mid post-release quiet", bad, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
